instr_fetch_controller: RTL and testbench
=========================================

INSTR_FETCH_CONTROLLER -- requirements
Module: instr_fetch_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N, 32, address width.
- TIMEOUT, 16, maximum WAIT cycles before error (range 2..255).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- pc, in, N, current PC from the program counter register.
- flush, in, 1, redirect: discard the fetch in progress.
- mem_req, out, 1, instruction memory read request (registered).
- mem_addr, out, N, read address (registered).
- mem_ack, in, 1, read data valid.
- mem_rdata, in, 32, read data.
- instruction, out, 32, last accepted instruction word.
- instr_valid, out, 1, one-cycle strobe: instruction is new.
- wait_until_next_cycle_flag, out, 1, PC stall (1 = PC holds).
- fetch_error, out, 1, sticky fault flag.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, WAIT, DONE, DISCARD and ERROR.
REQ-005 IDLE, pc[1:0]!=0: next state ERROR, no request issued.
REQ-006 IDLE, pc aligned, flush=0: next edge sets mem_req=1 and mem_addr=pc, clears the timeout counter, and enters WAIT.
REQ-007 IDLE with flush=1 SHALL remain in IDLE for that cycle.
REQ-008 WAIT SHALL hold mem_req=1 and mem_addr constant until mem_ack is sampled high.
REQ-009 WAIT with mem_ack=1 and flush=0 SHALL capture mem_rdata into instruction, clear mem_req, and enter DONE.
REQ-010 WAIT with flush=1 and mem_ack=1 in the same cycle SHALL drop the data, leave instruction unchanged, clear mem_req, and enter IDLE.
REQ-011 WAIT with flush=1 and mem_ack=0 SHALL enter DISCARD.
REQ-012 DISCARD SHALL keep mem_req=1 until mem_ack, drop that data, and then enter IDLE.
REQ-013 DISCARD SHALL ignore further flush pulses.
REQ-014 DONE SHALL last exactly one cycle with instr_valid=1, then enter IDLE.
REQ-015 wait_until_next_cycle_flag SHALL be 0 only in DONE, so the PC advances on the edge that ends DONE.
REQ-016 The timeout counter SHALL increment on each WAIT or DISCARD cycle without mem_ack.
REQ-017 When the counter reaches TIMEOUT, the next state SHALL be ERROR and mem_req SHALL be cleared.
REQ-018 ERROR SHALL be terminal until reset, with fetch_error=1, mem_req=0 and stall=1.
REQ-019 mem_ack while mem_req=0 SHALL be ignored.
REQ-020 instruction SHALL hold its value in every state except the DONE entry edge.
REQ-021 Minimum fetch period with zero-wait memory (ack in the first WAIT cycle) SHALL be 3 cycles: IDLE, WAIT, DONE.

Reset
REQ-022 reset_n=0 SHALL immediately, without a clock, force:
- state IDLE, mem_req=0, mem_addr=0;
- instruction=32'h00000013 (NOP), instr_valid=0;
- wait_until_next_cycle_flag=1, fetch_error=0, counter=0.
REQ-023 Reset asserted in WAIT or DISCARD SHALL abandon the request; the first ack after release SHALL be ignored under REQ-019.
REQ-024 The first request after release SHALL occur on the second rising edge after reset_n rises.

Verification
REQ-025 Benches SHALL cover:
- Zero-wait memory, pc=0x0, ack with rdata=0x00500093 in the first WAIT cycle -> instruction=0x00500093 and instr_valid=1 in the third cycle, stall=0 for that cycle only.
- 3-cycle memory latency, pc=0x4 -> mem_req high 3 cycles with mem_addr=0x4, stall=1 throughout, then DONE.
- flush in the 2nd WAIT cycle, ack 2 cycles later with 0xDEADBEEF -> instruction keeps its prior value, no instr_valid, then a new request to the new pc.
- pc=0x6 -> fetch_error=1 one cycle later, mem_req never asserted, stall stays 1 until reset.
- No ack for 16 WAIT cycles -> ERROR, mem_req=0, fetch_error=1.
- reset_n low mid-WAIT -> outputs immediately at reset values, and a later stray ack does not set instr_valid.

Source files
------------

// File: rtl/instr_fetch_controller_if.sv
// Instruction memory read bus between the fetch controller (master) and the
// instruction memory (slave): a held request with address, and an ack with data.
interface instr_fetch_controller_if #(
    parameter int N = 32
);
    logic         mem_req;
    logic [N-1:0] mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_controller.sv
// Instruction fetch controller: issues one aligned read per PC value, holds the
// PC stalled until the word is accepted, supports redirect (flush) with
// in-flight data discard, and latches a sticky fault on misalignment or timeout.
module instr_fetch_controller #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N-1:0]              pc,
    input  logic                      flush,
    instr_fetch_controller_if.master  mem,
    output logic [31:0]               instruction,
    output logic                      instr_valid,
    output logic                      wait_until_next_cycle_flag,
    output logic                      fetch_error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        DONE    = 3'd2,
        DISCARD = 3'd3,
        ERROR   = 3'd4
    } state_t;

    localparam logic [7:0]  L_TIMEOUT = 8'(TIMEOUT);
    localparam logic [31:0] L_NOP     = 32'h0000_0013;

    state_t       r_state;
    logic [7:0]   r_cnt;
    logic         r_armed;
    logic         r_mem_req;
    logic [N-1:0] r_mem_addr;
    logic [31:0]  r_instruction;
    logic         r_instr_valid;
    logic         r_stall;
    logic         r_fetch_error;

    logic         w_aligned;
    logic [7:0]   w_cnt_inc;
    logic         w_timeout;

    assign w_aligned = (pc[1:0] == 2'b00);
    assign w_cnt_inc = r_cnt + 8'd1;
    // The cycle being counted now is the TIMEOUT-th one without an ack.
    assign w_timeout = (w_cnt_inc == L_TIMEOUT);

    assign mem.mem_req                = r_mem_req;
    assign mem.mem_addr               = r_mem_addr;
    assign instruction                = r_instruction;
    assign instr_valid                = r_instr_valid;
    assign wait_until_next_cycle_flag = r_stall;
    assign fetch_error                = r_fetch_error;

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= 8'd0;
            r_armed       <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instruction <= L_NOP;
            r_instr_valid <= 1'b0;
            r_stall       <= 1'b1;
            r_fetch_error <= 1'b0;
        end else begin
            // The first edge after reset release only arms the controller, so
            // the first request lands on the second edge.
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (!r_armed) begin
                        r_state <= IDLE;
                    end else if (!w_aligned) begin
                        r_state       <= ERROR;
                        r_fetch_error <= 1'b1;
                    end else if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_state    <= WAIT;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= pc;
                        r_cnt      <= 8'd0;
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (flush) begin
                            // Redirect in the ack cycle: the word is stale.
                            r_state <= IDLE;
                        end else begin
                            r_state       <= DONE;
                            r_instruction <= mem.mem_rdata;
                            r_instr_valid <= 1'b1;
                            r_stall       <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state       <= ERROR;
                        r_mem_req     <= 1'b0;
                        r_fetch_error <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (flush) begin
                            r_state <= DISCARD;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                DISCARD: begin
                    // The outstanding read must complete before a new one;
                    // flush here has nothing further to cancel.
                    if (mem.mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end else if (w_timeout) begin
                        r_state       <= ERROR;
                        r_mem_req     <= 1'b0;
                        r_fetch_error <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_state <= DISCARD;
                    end
                end
                DONE: begin
                    r_state       <= IDLE;
                    r_instr_valid <= 1'b0;
                    r_stall       <= 1'b1;
                end
                ERROR: begin
                    r_state       <= ERROR;
                    r_mem_req     <= 1'b0;
                    r_stall       <= 1'b1;
                    r_fetch_error <= 1'b1;
                end
                default: begin
                    r_state       <= IDLE;
                    r_mem_req     <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_stall       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_controller.sv
// Directed bench for instr_fetch_controller: each task drives one scenario and
// compares outputs against hand-derived values one time unit after the edge.
module tb_instr_fetch_controller;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        stall;
    logic        fetch_error;
    int          errors;
    int          checks;

    instr_fetch_controller_if #(.N(32)) bus ();

    instr_fetch_controller #(.N(32), .TIMEOUT(16)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .pc                         (pc),
        .flush                      (flush),
        .mem                        (bus),
        .instruction                (instruction),
        .instr_valid                (instr_valid),
        .wait_until_next_cycle_flag (stall),
        .fetch_error                (fetch_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] p);
        reset_n = 1'b0;
        flush = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        pc = p;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; flush = 1'b0; pc = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (instruction !== 32'h00000013) begin errors++; $display("FAIL rst_instr: got %h expected 00000013", instruction); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b expected 1", stall); end
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", fetch_error); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rel_edge1_req: got %b expected 0", bus.mem_req); end
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rel_edge2_req: got %b expected 1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rel_edge2_addr: got %h expected 0", bus.mem_addr); end
    endtask

    // Entered with the controller in its first WAIT cycle for pc=0.
    task automatic test_zero_wait();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00500093;
        tick();
        checks++; if (instruction !== 32'h00500093) begin errors++; $display("FAIL zw_instr: got %h expected 00500093", instruction); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b expected 1", instr_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zw_stall: got %b expected 0", stall); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL zw_req: got %b expected 0", bus.mem_req); end
        bus.mem_ack = 1'b0; pc = 32'h4;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL zw_valid_drop: got %b expected 0", instr_valid); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zw_stall_back: got %b expected 1", stall); end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin errors++; $display("FAIL lat_req%0d: got req=%b addr=%h expected req=1 addr=00000004", i, bus.mem_req, bus.mem_addr); end
            checks++; if (stall !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL lat_stall%0d: got stall=%b valid=%b expected stall=1 valid=0", i, stall, instr_valid); end
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00A00113;
        tick();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h00A00113) begin errors++; $display("FAIL lat_done: got valid=%b instr=%h expected valid=1 instr=00a00113", instr_valid, instruction); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL lat_req_off: got %b expected 0", bus.mem_req); end
        bus.mem_ack = 1'b0; pc = 32'h8;
        tick();
    endtask

    task automatic test_flush_discard();
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin errors++; $display("FAIL fl_req: got req=%b addr=%h expected req=1 addr=00000008", bus.mem_req, bus.mem_addr); end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fl_discard_req: got %b expected 1", bus.mem_req); end
        tick();
        // Data arrives now; a second flush pulse must change nothing.
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; flush = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b expected 0", instr_valid); end
        checks++; if (instruction !== 32'h00A00113) begin errors++; $display("FAIL fl_instr: got %h expected 00a00113", instruction); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fl_req_off: got %b expected 0", bus.mem_req); end
        bus.mem_ack = 1'b0; flush = 1'b0; pc = 32'h10;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin errors++; $display("FAIL fl_newreq: got req=%b addr=%h expected req=1 addr=00000010", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'h12345678) begin errors++; $display("FAIL fl_newdone: got valid=%b instr=%h expected valid=1 instr=12345678", instr_valid, instruction); end
        bus.mem_ack = 1'b0; pc = 32'h14;
        tick();
    endtask

    task automatic test_flush_with_ack();
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h14) begin errors++; $display("FAIL fa_req: got req=%b addr=%h expected req=1 addr=00000014", bus.mem_req, bus.mem_addr); end
        flush = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        tick();
        checks++; if (bus.mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL fa_drop: got req=%b valid=%b expected req=0 valid=0", bus.mem_req, instr_valid); end
        checks++; if (instruction !== 32'h12345678) begin errors++; $display("FAIL fa_instr: got %h expected 12345678", instruction); end
        flush = 1'b0; bus.mem_ack = 1'b0;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h14) begin errors++; $display("FAIL fa_reissue: got req=%b addr=%h expected req=1 addr=00000014", bus.mem_req, bus.mem_addr); end
    endtask

    // Entered just after a request edge, with no ack ever arriving.
    task automatic test_timeout();
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if (bus.mem_req !== 1'b1 || fetch_error !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got req=%b err=%b expected req=1 err=0", i, bus.mem_req, fetch_error); end
        end
        tick();
        checks++; if (bus.mem_req !== 1'b0 || fetch_error !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL to_error: got req=%b err=%b stall=%b expected req=0 err=1 stall=1", bus.mem_req, fetch_error, stall); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        tick();
        checks++; if (instr_valid !== 1'b0 || fetch_error !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_sticky: got valid=%b err=%b req=%b expected valid=0 err=1 req=0", instr_valid, fetch_error, bus.mem_req); end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_misaligned();
        do_reset(32'h6);
        tick();
        tick();
        checks++; if (fetch_error !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_err: got err=%b req=%b expected err=1 req=0", fetch_error, bus.mem_req); end
        pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b1 || fetch_error !== 1'b1) begin errors++; $display("FAIL mis_hold%0d: got req=%b stall=%b err=%b expected req=0 stall=1 err=1", i, bus.mem_req, stall, fetch_error); end
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(32'h20);
        tick();
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20) begin errors++; $display("FAIL rw_req: got req=%b addr=%h expected req=1 addr=00000020", bus.mem_req, bus.mem_addr); end
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rw_async: got req=%b addr=%h expected req=0 addr=00000000", bus.mem_req, bus.mem_addr); end
        checks++; if (instruction !== 32'h00000013 || stall !== 1'b1 || fetch_error !== 1'b0) begin errors++; $display("FAIL rw_async_out: got instr=%h stall=%b err=%b expected instr=00000013 stall=1 err=0", instruction, stall, fetch_error); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBADC0DE5;
        tick();
        checks++; if (instr_valid !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rw_stray1: got valid=%b req=%b expected valid=0 req=0", instr_valid, bus.mem_req); end
        tick();
        checks++; if (instr_valid !== 1'b0 || instruction !== 32'h00000013) begin errors++; $display("FAIL rw_stray2: got valid=%b instr=%h expected valid=0 instr=00000013", instr_valid, instruction); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20) begin errors++; $display("FAIL rw_first_req: got req=%b addr=%h expected req=1 addr=00000020", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_flush_discard();
        test_flush_with_ack();
        test_timeout();
        test_misaligned();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
